// File: rtl/nv_blkbox_sink_misr_if.sv
// Valid/ready beat channel into the blackbox sink MISR.
interface nv_blkbox_sink_misr_if #(parameter int DW = 32);
    logic          snk_valid;
    logic          snk_ready;
    logic [DW-1:0] snk_data;

    modport master (output snk_valid, output snk_data, input  snk_ready);
    modport slave  (input  snk_valid, input  snk_data, output snk_ready);
endinterface

// File: rtl/nv_blkbox_sink_misr.sv
// Observation sink: compresses accepted beats into a 32-bit MISR, counts beats
// and keeps sticky nonzero/overflow flags; freeze holds state and backpressures.
module nv_blkbox_sink_misr #(
    parameter int DW = 32,
    parameter int CW = 16
) (
    input  logic                        nvdla_core_clk,
    input  logic                        nvdla_core_rstn,
    nv_blkbox_sink_misr_if.slave        snk,
    input  logic                        clr,
    input  logic                        freeze,
    output logic [31:0]                 sig_out,
    output logic [CW-1:0]               beat_cnt,
    output logic                        nonzero_seen,
    output logic                        cnt_ovf,
    output logic [1:0]                  state_o
);
    typedef enum logic [1:0] {IDLE = 2'b00, ACTIVE = 2'b01, FROZEN = 2'b10} state_e;

    localparam logic [31:0]   POLY    = 32'h04C11DB7;
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    state_e        state_q, state_d;
    logic [31:0]   sig_q, sig_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          nz_q, nz_d;
    logic          ovf_q, ovf_d;
    logic          ready_q;

    logic [DW-1:0] data_w;
    logic [31:0]   data_ext;
    logic          accept;

    assign data_w   = snk.snk_data;
    assign data_ext = 32'(data_w);
    // clr wins over an offered beat, so it gates acceptance here.
    assign accept   = snk.snk_valid & ready_q & ~clr;

    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        nz_d    = nz_q;
        ovf_d   = ovf_q;
        if (clr) begin
            state_d = IDLE;
            sig_d   = 32'hFFFFFFFF;
            cnt_d   = '0;
            nz_d    = 1'b0;
            ovf_d   = 1'b0;
        end else begin
            if (accept) begin
                sig_d = {sig_q[30:0], 1'b0} ^ (sig_q[31] ? POLY : 32'h0) ^ data_ext;
                nz_d  = nz_q | (data_ext != 32'h0);
                if (cnt_q == CNT_MAX) ovf_d = 1'b1;
                else                  cnt_d = cnt_q + 1'b1;
            end
            case (state_q)
                IDLE:    if (freeze) state_d = FROZEN;
                         else if (accept) state_d = ACTIVE;
                ACTIVE:  if (freeze) state_d = FROZEN;
                FROZEN:  if (!freeze) state_d = (cnt_q != '0) ? ACTIVE : IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state_q <= IDLE;
            sig_q   <= 32'hFFFFFFFF;
            cnt_q   <= '0;
            nz_q    <= 1'b0;
            ovf_q   <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            nz_q    <= nz_d;
            ovf_q   <= ovf_d;
            // Ready tracks the upcoming state so backpressure lines up with FROZEN.
            ready_q <= (state_d != FROZEN);
        end
    end

    assign snk.snk_ready = ready_q;
    assign sig_out       = sig_q;
    assign beat_cnt      = cnt_q;
    assign nonzero_seen  = nz_q;
    assign cnt_ovf       = ovf_q;
    assign state_o       = state_q;
endmodule

// File: tb/tb_nv_blkbox_sink_misr.sv
// Directed bench for nv_blkbox_sink_misr: three instances (DW32/CW16, DW32/CW4, DW1/CW16).
module tb_nv_blkbox_sink_misr;
    logic clk, rstn, clr, freeze, valid;
    logic [31:0] data;
    int nvec = 0;
    int nmis = 0;

    logic [31:0] sig0, sig1, sig2;
    logic [15:0] cnt0, cnt2;
    logic [3:0]  cnt1;
    logic nz0, nz1, nz2, ovf0, ovf1, ovf2;
    logic [1:0] st0, st1, st2;

    nv_blkbox_sink_misr_if #(.DW(32)) if0 ();
    nv_blkbox_sink_misr_if #(.DW(32)) if1 ();
    nv_blkbox_sink_misr_if #(.DW(1))  if2 ();

    assign if0.snk_valid = valid;
    assign if0.snk_data  = data;
    assign if1.snk_valid = valid;
    assign if1.snk_data  = data;
    assign if2.snk_valid = valid;
    assign if2.snk_data  = data[0];

    nv_blkbox_sink_misr #(.DW(32), .CW(16)) u0 (
        .nvdla_core_clk(clk), .nvdla_core_rstn(rstn), .snk(if0), .clr(clr), .freeze(freeze),
        .sig_out(sig0), .beat_cnt(cnt0), .nonzero_seen(nz0), .cnt_ovf(ovf0), .state_o(st0));
    nv_blkbox_sink_misr #(.DW(32), .CW(4)) u1 (
        .nvdla_core_clk(clk), .nvdla_core_rstn(rstn), .snk(if1), .clr(clr), .freeze(freeze),
        .sig_out(sig1), .beat_cnt(cnt1), .nonzero_seen(nz1), .cnt_ovf(ovf1), .state_o(st1));
    nv_blkbox_sink_misr #(.DW(1), .CW(16)) u2 (
        .nvdla_core_clk(clk), .nvdla_core_rstn(rstn), .snk(if2), .clr(clr), .freeze(freeze),
        .sig_out(sig2), .beat_cnt(cnt2), .nonzero_seen(nz2), .cnt_ovf(ovf2), .state_o(st2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] misr(input logic [31:0] s, input logic [31:0] d);
        return {s[30:0], 1'b0} ^ (s[31] ? 32'h04C11DB7 : 32'h0) ^ d;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b1; clr = 1'b0; freeze = 1'b0; valid = 1'b0; data = '0;
        #2 rstn = 1'b0;
        #1;
        nvec++; if (sig0 !== 32'hFFFFFFFF) begin nmis++; $display("FAIL reset_sig: got %h want ffffffff", sig0); end
        nvec++; if (cnt0 !== 16'd0) begin nmis++; $display("FAIL reset_cnt: got %0d want 0", cnt0); end
        nvec++; if (nz0 !== 1'b0) begin nmis++; $display("FAIL reset_nz: got %b want 0", nz0); end
        nvec++; if (ovf0 !== 1'b0) begin nmis++; $display("FAIL reset_ovf: got %b want 0", ovf0); end
        nvec++; if (st0 !== 2'b00) begin nmis++; $display("FAIL reset_state: got %b want 00", st0); end
        nvec++; if (if0.snk_ready !== 1'b1) begin nmis++; $display("FAIL reset_ready: got %b want 1", if0.snk_ready); end
        step(); step();
        rstn = 1'b1;
    endtask

    task automatic test_zero_beat();
        valid = 1'b1; data = 32'h0;
        step();
        valid = 1'b0;
        nvec++; if (sig0 !== 32'hFB3EE249) begin nmis++; $display("FAIL zero_sig: got %h want fb3ee249", sig0); end
        nvec++; if (cnt0 !== 16'd1) begin nmis++; $display("FAIL zero_cnt: got %0d want 1", cnt0); end
        nvec++; if (nz0 !== 1'b0) begin nmis++; $display("FAIL zero_nz: got %b want 0", nz0); end
        nvec++; if (st0 !== 2'b01) begin nmis++; $display("FAIL zero_state: got %b want 01", st0); end
    endtask

    task automatic test_nonzero_sticky();
        do_clr();
        valid = 1'b1; data = 32'h1;
        step();
        nvec++; if (nz0 !== 1'b1) begin nmis++; $display("FAIL nz_set: got %b want 1", nz0); end
        nvec++; if (sig0 !== 32'hFB3EE248) begin nmis++; $display("FAIL nz_sig: got %h want fb3ee248", sig0); end
        data = 32'h0;
        for (int i = 0; i < 10; i++) begin
            step();
            nvec++; if (nz0 !== 1'b1) begin nmis++; $display("FAIL nz_sticky%0d: got %b want 1", i, nz0); end
        end
        valid = 1'b0;
        nvec++; if (cnt0 !== 16'd11) begin nmis++; $display("FAIL nz_cnt: got %0d want 11", cnt0); end
        do_clr();
        nvec++; if (nz0 !== 1'b0) begin nmis++; $display("FAIL nz_clr: got %b want 0", nz0); end
        nvec++; if (sig0 !== 32'hFFFFFFFF) begin nmis++; $display("FAIL nz_clr_sig: got %h want ffffffff", sig0); end
    endtask

    task automatic test_freeze();
        logic [31:0] s;
        do_clr();
        s = 32'hFFFFFFFF;
        valid = 1'b1;
        data = 32'h12345678; step(); s = misr(s, 32'h12345678);
        data = 32'hA5A5A5A5; step(); s = misr(s, 32'hA5A5A5A5);
        // beat offered as freeze rises is still counted
        freeze = 1'b1; data = 32'hDEADBEEF; step(); s = misr(s, 32'hDEADBEEF);
        for (int i = 0; i < 5; i++) begin
            nvec++; if (st0 !== 2'b10) begin nmis++; $display("FAIL frz_state%0d: got %b want 10", i, st0); end
            nvec++; if (if0.snk_ready !== 1'b0) begin nmis++; $display("FAIL frz_ready%0d: got %b want 0", i, if0.snk_ready); end
            nvec++; if (sig0 !== s) begin nmis++; $display("FAIL frz_sig%0d: got %h want %h", i, sig0, s); end
            nvec++; if (cnt0 !== 16'd3) begin nmis++; $display("FAIL frz_cnt%0d: got %0d want 3", i, cnt0); end
            if (i < 4) begin data = $urandom | 32'h1; step(); end
        end
        freeze = 1'b0; valid = 1'b0;
        step();
        nvec++; if (st0 !== 2'b01) begin nmis++; $display("FAIL frz_rel_state: got %b want 01", st0); end
        nvec++; if (if0.snk_ready !== 1'b1) begin nmis++; $display("FAIL frz_rel_ready: got %b want 1", if0.snk_ready); end
        nvec++; if (sig0 !== s) begin nmis++; $display("FAIL frz_rel_sig: got %h want %h", sig0, s); end
        do_clr();
        freeze = 1'b1;
        step();
        nvec++; if (st0 !== 2'b10) begin nmis++; $display("FAIL frz_idle_state: got %b want 10", st0); end
        freeze = 1'b0;
        step();
        nvec++; if (st0 !== 2'b00) begin nmis++; $display("FAIL frz_idle_rel: got %b want 00", st0); end
        nvec++; if (if0.snk_ready !== 1'b1) begin nmis++; $display("FAIL frz_idle_ready: got %b want 1", if0.snk_ready); end
    endtask

    task automatic test_saturation();
        logic [31:0] s;
        do_clr();
        s = 32'hFFFFFFFF;
        valid = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            data = 32'(i * 3);
            step();
            s = misr(s, 32'(i * 3));
            if (i == 15) begin
                nvec++; if (cnt1 !== 4'd15) begin nmis++; $display("FAIL sat_cnt15: got %0d want 15", cnt1); end
                nvec++; if (ovf1 !== 1'b0) begin nmis++; $display("FAIL sat_ovf15: got %b want 0", ovf1); end
            end
            if (i >= 16) begin
                nvec++; if (cnt1 !== 4'd15) begin nmis++; $display("FAIL sat_cnt%0d: got %0d want 15", i, cnt1); end
                nvec++; if (ovf1 !== 1'b1) begin nmis++; $display("FAIL sat_ovf%0d: got %b want 1", i, ovf1); end
            end
        end
        valid = 1'b0;
        nvec++; if (sig1 !== s) begin nmis++; $display("FAIL sat_sig: got %h want %h", sig1, s); end
        nvec++; if (cnt0 !== 16'd17) begin nmis++; $display("FAIL sat_cnt_wide: got %0d want 17", cnt0); end
        nvec++; if (ovf0 !== 1'b0) begin nmis++; $display("FAIL sat_ovf_wide: got %b want 0", ovf0); end
    endtask

    task automatic test_clr_override();
        valid = 1'b1; data = 32'h5;
        step();
        clr = 1'b1; freeze = 1'b1; data = 32'h7;
        step();
        clr = 1'b0; freeze = 1'b0; valid = 1'b0;
        nvec++; if (sig0 !== 32'hFFFFFFFF) begin nmis++; $display("FAIL clr_sig: got %h want ffffffff", sig0); end
        nvec++; if (cnt0 !== 16'd0) begin nmis++; $display("FAIL clr_cnt: got %0d want 0", cnt0); end
        nvec++; if (nz0 !== 1'b0) begin nmis++; $display("FAIL clr_nz: got %b want 0", nz0); end
        nvec++; if (ovf1 !== 1'b0) begin nmis++; $display("FAIL clr_ovf: got %b want 0", ovf1); end
        nvec++; if (st0 !== 2'b00) begin nmis++; $display("FAIL clr_state: got %b want 00", st0); end
        nvec++; if (if0.snk_ready !== 1'b1) begin nmis++; $display("FAIL clr_ready: got %b want 1", if0.snk_ready); end
    endtask

    task automatic test_async_reset();
        do_clr();
        valid = 1'b1;
        for (int i = 0; i < 5; i++) begin data = $urandom | 32'h100; step(); end
        freeze = 1'b1;
        #2 rstn = 1'b0;
        #1;
        nvec++; if (sig0 !== 32'hFFFFFFFF) begin nmis++; $display("FAIL arst_sig: got %h want ffffffff", sig0); end
        nvec++; if (cnt0 !== 16'd0) begin nmis++; $display("FAIL arst_cnt: got %0d want 0", cnt0); end
        nvec++; if (nz0 !== 1'b0) begin nmis++; $display("FAIL arst_nz: got %b want 0", nz0); end
        nvec++; if (st0 !== 2'b00) begin nmis++; $display("FAIL arst_state: got %b want 00", st0); end
        valid = 1'b0; freeze = 1'b0;
        step();
        rstn = 1'b1;
        valid = 1'b1; data = 32'h0;
        step();
        valid = 1'b0;
        nvec++; if (sig0 !== 32'hFB3EE249) begin nmis++; $display("FAIL arst_first_sig: got %h want fb3ee249", sig0); end
        nvec++; if (cnt0 !== 16'd1) begin nmis++; $display("FAIL arst_first_cnt: got %0d want 1", cnt0); end
    endtask

    task automatic test_random_stream();
        logic [31:0] s0, s2;
        logic        v;
        logic [31:0] d;
        do_clr();
        s0 = 32'hFFFFFFFF; s2 = 32'hFFFFFFFF;
        for (int i = 0; i < 1000; i++) begin
            v = 1'($urandom_range(0, 1));
            d = $urandom;
            valid = v; data = d;
            step();
            if (v) begin
                s0 = misr(s0, d);
                s2 = misr(s2, {31'b0, d[0]});
            end
            nvec++; if (sig0 !== s0) begin nmis++; $display("FAIL rnd32_%0d: got %h want %h", i, sig0, s0); end
            nvec++; if (sig2 !== s2) begin nmis++; $display("FAIL rnd1_%0d: got %h want %h", i, sig2, s2); end
        end
        valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_zero_beat();
        test_nonzero_sticky();
        test_freeze();
        test_saturation();
        test_clr_override();
        test_async_reset();
        test_random_stream();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
